// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter: shares the external memory-mapped bus between two masters.
//
// Grants one of two req/ack masters at a time with round-robin arbitration
// on contention. The granted command is registered onto the slave bus and
// held there until the slave signals s_rdy or a wait-state timeout aborts
// the access. Completion is reported to the owner as a one-cycle ack pulse,
// with err high on timeout.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   m0_* / m1_*              master request side: req, we, addr, wdata in;
//                            ack, err, rdata (registered) out
//   s_re, s_we, s_addr,      slave command, all registered
//   s_wdata
//   s_rdata, s_rdy           slave read data and completion
//   busy, owner              arbiter occupied / index of the granted master
module ext_bus_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              s_re,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rdy,

  output logic              busy,
  output logic              owner
);

  // Wide enough to hold TIMEOUT; the counter stops at TIMEOUT-1 so it never wraps.
  localparam int unsigned CNT_W = (TIMEOUT + 1 > 2) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state, state_n;
  logic              last, last_n;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_n;

  logic              m0_ack_n, m1_ack_n, m0_err_n, m1_err_n;
  logic [DATA_W-1:0] m0_rdata_n, m1_rdata_n;
  logic              s_re_n, s_we_n;
  logic [ADDR_W-1:0] s_addr_n;
  logic [DATA_W-1:0] s_wdata_n;
  logic              busy_n, owner_n;
  logic              grant;
  logic              finish;
  logic              timed_out;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      wait_cnt <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      s_re     <= 1'b0;
      s_we     <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      busy     <= 1'b0;
      owner    <= 1'b0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      wait_cnt <= wait_cnt_n;
      m0_ack   <= m0_ack_n;
      m1_ack   <= m1_ack_n;
      m0_err   <= m0_err_n;
      m1_err   <= m1_err_n;
      m0_rdata <= m0_rdata_n;
      m1_rdata <= m1_rdata_n;
      s_re     <= s_re_n;
      s_we     <= s_we_n;
      s_addr   <= s_addr_n;
      s_wdata  <= s_wdata_n;
      busy     <= busy_n;
      owner    <= owner_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    last_n     = last;
    wait_cnt_n = wait_cnt;
    m0_ack_n   = 1'b0;
    m1_ack_n   = 1'b0;
    m0_err_n   = 1'b0;
    m1_err_n   = 1'b0;
    m0_rdata_n = m0_rdata;
    m1_rdata_n = m1_rdata;
    s_re_n     = s_re;
    s_we_n     = s_we;
    s_addr_n   = s_addr;
    s_wdata_n  = s_wdata;
    busy_n     = busy;
    owner_n    = owner;
    grant      = 1'b0;
    finish     = 1'b0;
    timed_out  = 1'b0;

    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On contention the master that did not own the bus last wins.
          grant      = (m0_req && m1_req) ? ~last : m1_req;
          owner_n    = grant;
          s_addr_n   = grant ? m1_addr  : m0_addr;
          s_wdata_n  = grant ? m1_wdata : m0_wdata;
          s_we_n     = grant ? m1_we    : m0_we;
          s_re_n     = grant ? ~m1_we   : ~m0_we;
          wait_cnt_n = '0;
          busy_n     = 1'b1;
          state_n    = ACCESS;
        end
      end

      ACCESS: begin
        // s_rdy is checked first so a late ready on the last cycle still succeeds.
        if (s_rdy) begin
          finish = 1'b1;
          if (s_re) begin
            if (owner) m1_rdata_n = s_rdata;
            else       m0_rdata_n = s_rdata;
          end
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          finish    = 1'b1;
          timed_out = 1'b1;
          if (s_re) begin
            if (owner) m1_rdata_n = '1;
            else       m0_rdata_n = '1;
          end
        end else begin
          wait_cnt_n = wait_cnt + CNT_W'(1);
        end

        if (finish) begin
          s_re_n  = 1'b0;
          s_we_n  = 1'b0;
          state_n = DONE;
          if (owner) begin
            m1_ack_n = 1'b1;
            m1_err_n = timed_out;
          end else begin
            m0_ack_n = 1'b1;
            m0_err_n = timed_out;
          end
        end
      end

      DONE: begin
        last_n  = owner;
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: begin
        s_re_n  = 1'b0;
        s_we_n  = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

endmodule
